id_ex: RTL and testbench
========================

ID_EX -- requirements
Module: id_ex

Interface
REQ-001 Parameters: none; all widths SHALL come from the shared defines file (RegBus 32, RegAddrBus 5, AluOpBus 8, AluSelBus 3, InstAddrBus 32).
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 flush  input  1  synchronous pipeline flush.
REQ-006 id_valid  input  1  decode-stage payload valid.
REQ-007 id_ready  output  1  stage can accept payload.
REQ-008 id_pc, id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg  input  32/8/3/32/32/5/1  decoded payload.
REQ-009 ex_valid  output  1  execute-stage payload valid.
REQ-010 ex_ready  input  1  execute stage consumes payload.
REQ-011 ex_pc, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg  output  32/8/3/32/32/5/1  registered payload.

Function
REQ-012 accept = id_valid & id_ready; consume = ex_valid & ex_ready; both SHALL be evaluated on the same rising edge.
REQ-013 Storage SHALL be a main register plus one skid register, tracked by states EMPTY, FULL, SKID.
REQ-014 EMPTY: accept -> FULL, main <= input.
REQ-015 FULL: accept & consume -> FULL, main <= input; accept & !consume -> SKID, skid <= input; !accept & consume -> EMPTY; neither -> hold.
REQ-016 SKID: consume -> FULL, main <= skid; otherwise hold; accept is impossible because id_ready is 0.
REQ-017 id_ready SHALL be a registered output, 1 in EMPTY/FULL and 0 in SKID; no combinational path from ex_ready to id_ready.
REQ-018 ex_valid SHALL be 1 in FULL/SKID and 0 in EMPTY; ex_* SHALL always drive the main register.
REQ-019 While ex_valid = 0, ex_* SHALL read NOP: EXE_NOP_OP, EXE_RES_NOP, NOPRegAddr, WriteDisable, ZeroWord operands, pc 0.
REQ-020 Latency SHALL be one cycle from accept to ex_valid; sustained throughput SHALL be one payload per cycle when ex_ready = 1.
REQ-021 Payload SHALL be held bit-stable while ex_valid = 1 and ex_ready = 0.
REQ-022 flush SHALL take priority over every other event: next state EMPTY, both registers NOP, and a same-cycle accept is discarded.
REQ-023 Payload SHALL NOT be reordered, duplicated or dropped, except by flush.

Reset
REQ-024 While rst = 0, the block SHALL be asynchronously forced to: state EMPTY, ex_valid 0, id_ready 1, all ex_* at NOP values, skid cleared.
REQ-025 Reset asserted mid-transfer SHALL discard both entries; after release, the first edge SHALL behave as EMPTY.

Configuration
REQ-026 Macro ID_EX_PERF_EN defined: output perf_bubble_cnt (32 bits) SHALL count cycles with ex_valid = 0 and ex_ready = 1, saturating at 32'hFFFFFFFF, reset to 0, and not cleared by flush.
REQ-027 Macro ID_EX_PERF_EN undefined: the port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-028 The EMPTY/FULL/SKID state encodings (2 bits) and the NOP payload constants SHALL live in the shared defines file beside the existing EXE_* and NOP defines.
REQ-029 One sub-module, id_ex_payload_reg, SHALL hold a single payload entry with load and clear; it is instantiated twice (main, skid).

Verification
REQ-030 Reset: rst = 0 while id_valid = 1 -> ex_valid 0, id_ready 1, ex_aluop EXE_NOP_OP, ex_wd 0; on release, nothing emitted.
REQ-031 Streaming: ex_ready = 1; accept ORI payloads pc 0x0, 0x4, 0x8 on consecutive edges -> each appears on ex_* exactly one cycle later, in order, with no gaps.
REQ-032 Backpressure: ex_ready = 0 with 2 accepts (pc 0x10, 0x14) -> state SKID, id_ready 0, ex_pc held at 0x10; ex_ready = 1 -> 0x10 then 0x14, then EMPTY.
REQ-033 Flush: in SKID, flush = 1 together with id_valid = 1 (pc 0x20) -> next cycle EMPTY, ex_valid 0, ex_wreg 0; pc 0x20 never emitted.
REQ-034 Simultaneous events: in FULL, accept and consume on the same edge with ex_reg1 0x1234 and id_reg1 0x5678 -> stays FULL, ex_reg1 = 0x5678.
REQ-035 ID_EX_PERF_EN: 5 idle cycles with ex_ready = 1, then flush -> perf_bubble_cnt = 5 and unchanged by the flush; preloaded at 0xFFFFFFFF -> stays 0xFFFFFFFF.

Source files
------------

// File: rtl/id_ex_pkg.sv
// Shared widths, NOP payload constants and state encodings for the ID/EX pipeline register.
// Imported by id_ex and id_ex_payload_reg.
package id_ex_pkg;

  localparam int RegBus      = 32;
  localparam int RegAddrBus  = 5;
  localparam int AluOpBus    = 8;
  localparam int AluSelBus   = 3;
  localparam int InstAddrBus = 32;

  localparam logic [AluOpBus-1:0]   EXE_NOP_OP    = 8'b0000_0000;
  localparam logic [AluOpBus-1:0]   EXE_ORI_OP    = 8'b0010_0101;
  localparam logic [AluSelBus-1:0]  EXE_RES_NOP   = 3'b000;
  localparam logic [AluSelBus-1:0]  EXE_RES_LOGIC = 3'b001;
  localparam logic [RegAddrBus-1:0] NOPRegAddr    = 5'b00000;
  localparam logic                  WriteDisable  = 1'b0;
  localparam logic                  WriteEnable   = 1'b1;
  localparam logic [RegBus-1:0]     ZeroWord      = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } state_e;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [AluOpBus-1:0]    aluop;
    logic [AluSelBus-1:0]   alusel;
    logic [RegBus-1:0]      reg1;
    logic [RegBus-1:0]      reg2;
    logic [RegAddrBus-1:0]  wd;
    logic                   wreg;
  } payload_t;

  localparam int PayloadW = $bits(payload_t);

  localparam payload_t NOP_PAYLOAD = '{
    pc:     ZeroWord,
    aluop:  EXE_NOP_OP,
    alusel: EXE_RES_NOP,
    reg1:   ZeroWord,
    reg2:   ZeroWord,
    wd:     NOPRegAddr,
    wreg:   WriteDisable
  };

endpackage

// File: rtl/id_ex_payload_reg.sv
// One ID/EX payload entry with load and clear; clear wins and returns the entry to NOP.
module id_ex_payload_reg
  import id_ex_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                clear_i,
  input  logic [PayloadW-1:0] d_i,
  output logic [PayloadW-1:0] q_o
);

  logic [PayloadW-1:0] entry_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q <= NOP_PAYLOAD;
    end else if (clear_i) begin
      entry_q <= NOP_PAYLOAD;
    end else if (load_i) begin
      entry_q <= d_i;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/id_ex.sv
// ID/EX pipeline register with a one-entry skid buffer and registered id_ready.
// Optional bubble counter output perf_bubble_cnt when ID_EX_PERF_EN is defined.
module id_ex
  import id_ex_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [InstAddrBus-1:0] id_pc,
  input  logic [AluOpBus-1:0]    id_aluop,
  input  logic [AluSelBus-1:0]   id_alusel,
  input  logic [RegBus-1:0]      id_reg1,
  input  logic [RegBus-1:0]      id_reg2,
  input  logic [RegAddrBus-1:0]  id_wd,
  input  logic                   id_wreg,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [InstAddrBus-1:0] ex_pc,
  output logic [AluOpBus-1:0]    ex_aluop,
  output logic [AluSelBus-1:0]   ex_alusel,
  output logic [RegBus-1:0]      ex_reg1,
  output logic [RegBus-1:0]      ex_reg2,
  output logic [RegAddrBus-1:0]  ex_wd,
  output logic                   ex_wreg
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]            perf_bubble_cnt
`endif
);

  state_e   state_q, state_d;
  logic     id_ready_q;
  logic     accept, consume;
  logic     main_load, main_clear, main_from_skid;
  logic     skid_load, skid_clear;
  payload_t in_p, main_d, main_q, skid_q;

  assign in_p = '{pc: id_pc, aluop: id_aluop, alusel: id_alusel, reg1: id_reg1,
                  reg2: id_reg2, wd: id_wd, wreg: id_wreg};

  assign accept  = id_valid & id_ready_q;
  assign consume = ex_valid & ex_ready;

  // id_ready is registered from the next state so ex_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      id_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      id_ready_q <= (state_d != ST_SKID);
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_FULL;
        ST_FULL: begin
          if (accept && !consume)      state_d = ST_SKID;
          else if (!accept && consume) state_d = ST_EMPTY;
        end
        ST_SKID:  if (consume) state_d = ST_FULL;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_load      = 1'b0;
    main_clear     = flush;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = flush;
    ex_valid       = (state_q != ST_EMPTY);
    if (!flush) begin
      case (state_q)
        ST_EMPTY: main_load = accept;
        ST_FULL: begin
          main_load  = accept & consume;
          skid_load  = accept & ~consume;
          main_clear = ~accept & consume;
        end
        ST_SKID: begin
          main_load      = consume;
          main_from_skid = consume;
          skid_clear     = consume;
        end
        default: main_clear = 1'b1;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_p;

  id_ex_payload_reg u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load),
    .clear_i (main_clear),
    .d_i     (main_d),
    .q_o     (main_q)
  );

  id_ex_payload_reg u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .d_i     (in_p),
    .q_o     (skid_q)
  );

  assign id_ready  = id_ready_q;
  assign ex_pc     = main_q.pc;
  assign ex_aluop  = main_q.aluop;
  assign ex_alusel = main_q.alusel;
  assign ex_reg1   = main_q.reg1;
  assign ex_reg2   = main_q.reg2;
  assign ex_wd     = main_q.wd;
  assign ex_wreg   = main_q.wreg;

`ifdef ID_EX_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (!ex_valid && ex_ready && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_bubble_cnt = perf_q;
`endif

endmodule

// File: tb/tb_id_ex.sv
// Directed-vector bench for id_ex: reset, streaming, backpressure, flush, simultaneous events.
// Bubble-counter checks run only when ID_EX_PERF_EN is defined.
module tb_id_ex;
  import id_ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, id_valid, id_ready, ex_valid, ex_ready;
  logic [31:0] id_pc, id_reg1, id_reg2, ex_pc, ex_reg1, ex_reg2;
  logic [7:0]  id_aluop, ex_aluop;
  logic [2:0]  id_alusel, ex_alusel;
  logic [4:0]  id_wd, ex_wd;
  logic        id_wreg, ex_wreg;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubble_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  id_ex dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_aluop(id_aluop), .id_alusel(id_alusel),
    .id_reg1(id_reg1), .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
    .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg)
`ifdef ID_EX_PERF_EN
    , .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] r1);
    id_valid  = v;
    id_pc     = pc;
    id_aluop  = EXE_ORI_OP;
    id_alusel = EXE_RES_LOGIC;
    id_reg1   = r1;
    id_reg2   = pc + 32'd1;
    id_wd     = 5'd3;
    id_wreg   = 1'b1;
    if (v) $display("xfer: id_valid pc=%08h reg1=%08h ex_ready=%0b flush=%0b", pc, r1, ex_ready, flush);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    drive(1'b1, 32'h99, 32'h0);
    tick(); tick();
    // Reset held while id_valid is high
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_id_ready", id_ready, 1);
    chk("rst_aluop", ex_aluop, EXE_NOP_OP);
    chk("rst_wd", ex_wd, 0);
    chk("rst_pc", ex_pc, 0);
    drive(1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    chk("rel_ex_valid", ex_valid, 0);

    // Streaming
    ex_ready = 1'b1;
    drive(1'b1, 32'h0, 32'hA0);  tick();
    chk("s0_valid", ex_valid, 1); chk("s0_pc", ex_pc, 32'h0); chk("s0_op", ex_aluop, EXE_ORI_OP);
    drive(1'b1, 32'h4, 32'hA4);  tick();
    chk("s1_valid", ex_valid, 1); chk("s1_pc", ex_pc, 32'h4); chk("s1_reg1", ex_reg1, 32'hA4);
    drive(1'b1, 32'h8, 32'hA8);  tick();
    chk("s2_valid", ex_valid, 1); chk("s2_pc", ex_pc, 32'h8); chk("s2_reg2", ex_reg2, 32'h9);
    drive(1'b0, 32'h0, 32'h0);   tick();
    chk("s3_valid", ex_valid, 0); chk("s3_nop_pc", ex_pc, 0); chk("s3_nop_sel", ex_alusel, EXE_RES_NOP);

    // Backpressure into the skid entry
    ex_ready = 1'b0;
    drive(1'b1, 32'h10, 32'h1);  tick();
    chk("bp0_pc", ex_pc, 32'h10); chk("bp0_ready", id_ready, 1);
    drive(1'b1, 32'h14, 32'h2);  tick();
    chk("bp1_ready", id_ready, 0); chk("bp1_pc", ex_pc, 32'h10);
    drive(1'b1, 32'h18, 32'h3);  tick();
    chk("bp2_hold_pc", ex_pc, 32'h10); chk("bp2_ready", id_ready, 0);
    drive(1'b0, 32'h0, 32'h0);
    ex_ready = 1'b1;             tick();
    chk("bp3_pc", ex_pc, 32'h14); chk("bp3_valid", ex_valid, 1); chk("bp3_ready", id_ready, 1);
    tick();
    chk("bp4_valid", ex_valid, 0); chk("bp4_pc", ex_pc, 0);

    // Flush from SKID with a same-cycle valid
    ex_ready = 1'b0;
    drive(1'b1, 32'h30, 32'h5);  tick();
    drive(1'b1, 32'h34, 32'h6);  tick();
    chk("fl_pre_ready", id_ready, 0);
    flush = 1'b1;
    drive(1'b1, 32'h20, 32'h7);  tick();
    chk("fl_valid", ex_valid, 0); chk("fl_wreg", ex_wreg, 0); chk("fl_ready", id_ready, 1);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    ex_ready = 1'b1;             tick();
    chk("fl_after_valid", ex_valid, 0); chk("fl_after_pc", ex_pc, 0);

    // Flush in FULL discards same-cycle accept
    drive(1'b1, 32'h50, 32'h8);  tick();
    flush = 1'b1;
    drive(1'b1, 32'h54, 32'h9);  tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("flf_valid", ex_valid, 0);
    tick();
    chk("flf_after_valid", ex_valid, 0);

    // Simultaneous accept and consume in FULL
    ex_ready = 1'b0;
    drive(1'b1, 32'h40, 32'h1234); tick();
    chk("sim0_reg1", ex_reg1, 32'h1234);
    ex_ready = 1'b1;
    drive(1'b1, 32'h44, 32'h5678); tick();
    chk("sim1_valid", ex_valid, 1); chk("sim1_reg1", ex_reg1, 32'h5678); chk("sim1_ready", id_ready, 1);
    drive(1'b0, 32'h0, 32'h0);     tick();
    chk("sim2_valid", ex_valid, 0);

    // Asynchronous reset mid-transfer with both entries occupied
    ex_ready = 1'b0;
    drive(1'b1, 32'h60, 32'hB); tick();
    drive(1'b1, 32'h64, 32'hC); tick();
    drive(1'b0, 32'h0, 32'h0);
    rst = 1'b0; #1;
    chk("ar_valid", ex_valid, 0); chk("ar_ready", id_ready, 1); chk("ar_pc", ex_pc, 0);
    rst = 1'b1;
    ex_ready = 1'b1;
    tick();
    chk("ar_rel_valid", ex_valid, 0);

`ifdef ID_EX_PERF_EN
    ex_ready = 1'b0;
    rst = 1'b0; #1; rst = 1'b1;
    chk("pf_reset", perf_bubble_cnt, 0);
    ex_ready = 1'b1;
    repeat (5) tick();
    chk("pf_five", perf_bubble_cnt, 5);
    ex_ready = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    chk("pf_flush", perf_bubble_cnt, 5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
